data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the data memory byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port m0_req / m1_req, input, 1 bit each: access request from the CPU (m0) and the loader/debug port (m1).
REQ-006 The block SHALL have port mX_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port mX_addr, input, ADDR_W bits: byte address.
REQ-008 The block SHALL have ports mX_wdata, input, DATA_W bits, and mX_funct3, input, 3 bits: store data and access size per RV32I load/store funct3.
REQ-009 The block SHALL have ports mX_gnt, mX_rvalid, mX_err, output, 1 bit each, and mX_rdata, output, DATA_W bits.
REQ-010 The block SHALL have ports mem_read, mem_write, output, 1 bit each; mem_addr, output, ADDR_W bits; mem_wdata, output, DATA_W bits; mem_funct3, output, 3 bits; mem_rdata, input, DATA_W bits.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, ACCESS, RESP; the transitions are IDLE->ACCESS on any sampled request, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-013 The requests SHALL be sampled only in IDLE; on the IDLE->ACCESS edge, the winner's we/addr/wdata/funct3 SHALL be latched.
REQ-014 The winner's mX_gnt SHALL be a registered one-cycle pulse, high exactly during the ACCESS cycle.
REQ-015 A requester SHALL drop req in its gnt cycle; a req still high when the FSM re-enters IDLE SHALL be treated as a new request.
REQ-016 In ACCESS, the latched fields SHALL drive mem_addr, mem_wdata and mem_funct3, and exactly one of mem_read (load) or mem_write (store) SHALL be high for that single cycle.
REQ-017 Outside ACCESS, mem_read and mem_write SHALL be 0, and mem_addr, mem_wdata and mem_funct3 SHALL hold their last latched values.
REQ-018 At the ACCESS->RESP edge, a load SHALL capture mem_rdata into the winner's mX_rdata; a store SHALL set mX_rdata to 0.
REQ-019 The winner's mX_rvalid SHALL be a one-cycle pulse, high exactly during RESP, for both loads and stores.
REQ-020 The non-winner's gnt, rvalid and err SHALL stay 0, and its rdata SHALL be unchanged.
REQ-021 Latency SHALL be: req high in IDLE at cycle 0, gnt at cycle 1, rvalid at cycle 2, IDLE at cycle 3; peak throughput is one access per 3 cycles.
REQ-022 A misaligned access (funct3 010 with addr[1:0] != 0, or funct3 001/101 with addr[0] = 1) SHALL still pass through ACCESS with gnt, but mem_read/mem_write SHALL stay 0; in RESP, rvalid and err SHALL be 1 and rdata SHALL be 0.
REQ-023 mX_err SHALL be 0 at all other times.
REQ-024 Simultaneous m0_req and m1_req in IDLE SHALL be resolved per REQ-029 and REQ-030; the loser SHALL be served at the next IDLE if it still requests.
REQ-025 A single requester SHALL win regardless of arbitration history.

Reset
REQ-026 While rst = 1, state SHALL be IDLE, and all gnt, rvalid, err, rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_funct3 and busy outputs SHALL be 0.
REQ-027 While rst = 1, the last-grant register SHALL be set to 1 (m1).
REQ-028 A reset asserted in ACCESS or RESP SHALL abort the transaction with no rvalid pulse; after reset release, arbitration SHALL restart in IDLE.

Configuration
REQ-029 With macro DATA_MEM_ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the port not granted last, and the last-grant register SHALL update on every grant.
REQ-030 Without DATA_MEM_ARB_ROUND_ROBIN_EN, m0 SHALL always win a tie, and no last-grant register SHALL be synthesised.

Verification
REQ-031 m0 load, word, addr 0x10, memory word 0xDEADBEEF -> m0_gnt at cycle 1, mem_read=1 with mem_addr=0x10 at cycle 1, m0_rvalid=1 and m0_rdata=0xDEADBEEF at cycle 2.
REQ-032 m1 store, word, addr 0x20, wdata 0x12345678 -> mem_write=1 for exactly one cycle with mem_wdata=0x12345678; a later m0 load of 0x20 returns 0x12345678.
REQ-033 m0_req and m1_req held high for 4 transactions with DATA_MEM_ARB_ROUND_ROBIN_EN -> grant order m0, m1, m0, m1; without the macro -> m0, m0, m0, m0.
REQ-034 m0 load, word, addr 0x13 -> m0_gnt=1, mem_read stays 0, m0_rvalid=1, m0_err=1, m0_rdata=0.
REQ-035 rst asserted during ACCESS of an m1 store -> all outputs 0 immediately, no m1_rvalid, and the next m0 request after release is granted at cycle 1.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU m0, loader m1) arbiter for a single-ported data memory: IDLE/ACCESS/RESP, one access per 3 cycles.
// Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 always wins a tie.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;       // 0 = m0, 1 = m1
  logic                we_q, we_d;
  logic                mis_q, mis_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                rd_q, rd_d, wr_q, wr_d;

  logic                req_any;
  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [2:0]          sel_funct3;
  logic                sel_mis;

  assign req_any = m0_req | m1_req;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    pick = (m0_req && m1_req) ? ~last_q : ~m0_req;
    last_d = last_q;
    if (state_q == IDLE && req_any) last_d = pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb pick = ~m0_req;
`endif

  always_comb begin
    sel_we     = pick ? m1_we     : m0_we;
    sel_addr   = pick ? m1_addr   : m0_addr;
    sel_wdata  = pick ? m1_wdata  : m0_wdata;
    sel_funct3 = pick ? m1_funct3 : m0_funct3;
    sel_mis    = ((sel_funct3 == 3'b010) && (sel_addr[1:0] != 2'b00)) ||
                 (((sel_funct3 == 3'b001) || (sel_funct3 == 3'b101)) && sel_addr[0]);
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    mis_d     = mis_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = ACCESS;
          win_d    = pick;
          we_d     = sel_we;
          mis_d    = sel_mis;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          funct3_d = sel_funct3;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
          // Strobes are registered here so they are high exactly in ACCESS.
          rd_d     = ~sel_we & ~sel_mis;
          wr_d     = sel_we & ~sel_mis;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (win_q) begin
          rvalid1_d = 1'b1;
          err1_d    = mis_q;
          rdata1_d  = (we_q || mis_q) ? '0 : mem_rdata;
        end else begin
          rvalid0_d = 1'b1;
          err0_d    = mis_q;
          rdata0_d  = (we_q || mis_q) ? '0 : mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign m0_gnt     = gnt0_q;
  assign m1_gnt     = gnt1_q;
  assign m0_rvalid  = rvalid0_q;
  assign m1_rvalid  = rvalid1_q;
  assign m0_err     = err0_q;
  assign m1_err     = err1_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed and randomized transactions against a behavioural model.
module tb_data_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [2:0]    m0_funct3, m1_funct3;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_read, mem_write, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    mem_funct3;

  int tests_run = 0;
  int tests_failed = 0;

  // Environment memory (word per byte address) and the model's view of it.
  logic [31:0] tb_mem [256] = '{default: '0};
  logic [31:0] model_mem [256];
  logic        model_last;
  logic [31:0] exp_rdata [2];

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr] <= mem_wdata;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic [2:0] f, input logic [7:0] a);
    int unsigned size;
    int unsigned av;
    av = a;
    size = (f[1:0] == 2'd2) ? 4 : (f[1:0] == 2'd1) ? 2 : 1;
    return (av % size) != 0;
  endfunction

  task automatic model_pick(input logic r0, input logic r1, output logic win);
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    win = (r0 && r1) ? !model_last : !r0;
`else
    win = r0 ? 1'b0 : 1'b1;
`endif
    model_last = win;
  endtask

  task automatic model_complete(input logic win, input logic we, input logic [7:0] a,
                                input logic [31:0] wd, input logic [2:0] f);
    logic mis;
    mis = model_mis(f, a);
    if (we && !mis) model_mem[a] = wd;
    exp_rdata[win] = (we || mis) ? 32'h0 : model_mem[a];
  endtask

  task automatic model_reset;
    model_last   = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic drive(input logic p, input logic we, input logic [7:0] a,
                       input logic [31:0] wd, input logic [2:0] f);
    if (!p) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd; m0_funct3 = f;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_funct3 = f;
    end
  endtask

  task automatic drop_reqs;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    tests_run++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write, busy} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=0",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write, busy});
    end
    tests_run++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_funct3} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got m0_rdata=%h m1_rdata=%h addr=%h wdata=%h f3=%b want all 0",
               m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_funct3);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_req busy got=%b want=0", busy);
    end
  endtask

  task automatic test_load_store;
    logic        tp [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        twe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ta [4]  = '{8'h20, 8'h10, 8'h10, 8'h20};
    logic [31:0] twd [4] = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0};
    logic [31:0] trd [4] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678};
    logic        win;
    for (int i = 0; i < 4; i++) begin
      drive(tp[i], twe[i], ta[i], twd[i], 3'b010);
      model_pick(!tp[i], tp[i], win);
      @(negedge clk);
      drop_reqs();
      tests_run++;
      if ({m0_gnt, m1_gnt} !== (tp[i] ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("FAIL ls_gnt[%0d] got=%b", i, {m0_gnt, m1_gnt});
      end
      tests_run++;
      if ({mem_read, mem_write, mem_addr} !== {!twe[i], twe[i], ta[i]}) begin
        tests_failed++;
        $display("FAIL ls_mem_ctl[%0d] got rd=%b wr=%b addr=%h want rd=%b wr=%b addr=%h",
                 i, mem_read, mem_write, mem_addr, !twe[i], twe[i], ta[i]);
      end
      if (twe[i]) begin
        tests_run++;
        if (mem_wdata !== twd[i]) begin
          tests_failed++;
          $display("FAIL ls_wdata[%0d] got=%h want=%h", i, mem_wdata, twd[i]);
        end
      end
      @(negedge clk);
      model_complete(win, twe[i], ta[i], twd[i], 3'b010);
      tests_run++;
      if ({mem_read, mem_write} !== 2'b00) begin
        tests_failed++;
        $display("FAIL ls_strobe_len[%0d] got rd=%b wr=%b want 0", i, mem_read, mem_write);
      end
      tests_run++;
      if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== {!tp[i], tp[i], 2'b00}) begin
        tests_failed++;
        $display("FAIL ls_rvalid[%0d] got rv=%b err=%b", i, {m0_rvalid, m1_rvalid}, {m0_err, m1_err});
      end
      tests_run++;
      if ((tp[i] ? m1_rdata : m0_rdata) !== trd[i]) begin
        tests_failed++;
        $display("FAIL ls_rdata[%0d] got=%h want=%h", i, tp[i] ? m1_rdata : m0_rdata, trd[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned;
    logic        tp [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        twe [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  ta [5]  = '{8'h13, 8'h21, 8'h05, 8'h22, 8'h22};
    logic [2:0]  tf [5]  = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001};
    logic        win, mis;
    for (int i = 0; i < 5; i++) begin
      drive(tp[i], twe[i], ta[i], 32'hA5A5_0000 + i, tf[i]);
      model_pick(!tp[i], tp[i], win);
      mis = model_mis(tf[i], ta[i]);
      @(negedge clk);
      drop_reqs();
      tests_run++;
      if ({m0_gnt, m1_gnt, mem_read, mem_write} !== {!tp[i], tp[i], !twe[i] && !mis, twe[i] && !mis}) begin
        tests_failed++;
        $display("FAIL mis_access[%0d] got gnt=%b rd=%b wr=%b", i, {m0_gnt, m1_gnt}, mem_read, mem_write);
      end
      @(negedge clk);
      model_complete(win, twe[i], ta[i], 32'hA5A5_0000 + i, tf[i]);
      tests_run++;
      if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== {!tp[i], tp[i], !tp[i] && mis, tp[i] && mis}) begin
        tests_failed++;
        $display("FAIL mis_resp[%0d] got rv=%b err=%b want err=%b", i,
                 {m0_rvalid, m1_rvalid}, {m0_err, m1_err}, mis);
      end
      tests_run++;
      if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        tests_failed++;
        $display("FAIL mis_rdata[%0d] got %h/%h want %h/%h", i, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tie;
    logic [3:0] order;
    logic [3:0] want;
    logic       win;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 8'h10, 32'h0, 3'b010);
    drive(1'b1, 1'b0, 8'h20, 32'h0, 3'b010);
    order = '0;
    for (int k = 0; k < 4; k++) begin
      model_pick(1'b1, 1'b1, win);
      @(negedge clk);
      order[k] = m1_gnt;
      if (k == 3) drop_reqs();
      tests_run++;
      if ({m0_gnt, m1_gnt} !== (win ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("FAIL tie_gnt[%0d] got=%b want winner m%0d", k, {m0_gnt, m1_gnt}, win);
      end
      @(negedge clk);
      model_complete(win, 1'b0, win ? 8'h20 : 8'h10, 32'h0, 3'b010);
      tests_run++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {!win, win, exp_rdata[0], exp_rdata[1]}) begin
        tests_failed++;
        $display("FAIL tie_resp[%0d] got rv=%b rdata=%h/%h want %h/%h", k,
                 {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL tie_idle[%0d] busy got=%b want=0", k, busy);
      end
    end
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    want = 4'b1010;
`else
    want = 4'b0000;
`endif
    tests_run++;
    if (order !== want) begin
      tests_failed++;
      $display("FAIL tie_order got=%b want=%b (bit k = m1 won transaction k)", order, want);
    end
  endtask

  task automatic test_random;
    logic [2:0]  fsel [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic        r0, r1, win, mis;
    logic        we [2];
    logic [7:0]  a [2];
    logic [31:0] wd [2];
    logic [2:0]  f [2];
    int unsigned r;
    for (int unsigned it = 0; it < 60; it++) begin
      r  = $urandom_range(1, 3);
      r0 = r[0];
      r1 = r[1];
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        a[p]  = 8'($urandom_range(0, 47));
        wd[p] = $urandom;
        f[p]  = fsel[$urandom_range(0, 4)];
      end
      if (r0) drive(1'b0, we[0], a[0], wd[0], f[0]);
      if (r1) drive(1'b1, we[1], a[1], wd[1], f[1]);
      model_pick(r0, r1, win);
      mis = model_mis(f[win], a[win]);
      @(negedge clk);
      drop_reqs();
      tests_run++;
      if ({m0_gnt, m1_gnt, busy} !== {!win, win, 1'b1}) begin
        tests_failed++;
        $display("FAIL rnd_gnt[%0d] got gnt=%b busy=%b want winner m%0d", it, {m0_gnt, m1_gnt}, busy, win);
      end
      tests_run++;
      if ({mem_read, mem_write} !== {!we[win] && !mis, we[win] && !mis}) begin
        tests_failed++;
        $display("FAIL rnd_strobe[%0d] got rd=%b wr=%b", it, mem_read, mem_write);
      end
      tests_run++;
      if ({mem_addr, mem_wdata, mem_funct3} !== {a[win], wd[win], f[win]}) begin
        tests_failed++;
        $display("FAIL rnd_fields[%0d] got %h/%h/%b want %h/%h/%b", it,
                 mem_addr, mem_wdata, mem_funct3, a[win], wd[win], f[win]);
      end
      @(negedge clk);
      model_complete(win, we[win], a[win], wd[win], f[win]);
      tests_run++;
      if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== {!win, win, !win && mis, win && mis}) begin
        tests_failed++;
        $display("FAIL rnd_resp[%0d] got rv=%b err=%b", it, {m0_rvalid, m1_rvalid}, {m0_err, m1_err});
      end
      tests_run++;
      if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        tests_failed++;
        $display("FAIL rnd_rdata[%0d] got %h/%h want %h/%h", it, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end
      tests_run++;
      if ({mem_read, mem_write, mem_addr} !== {2'b00, a[win]}) begin
        tests_failed++;
        $display("FAIL rnd_hold[%0d] got rd=%b wr=%b addr=%h want addr=%h", it,
                 mem_read, mem_write, mem_addr, a[win]);
      end
      @(negedge clk);
      tests_run++;
      if ({busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 7'b0) begin
        tests_failed++;
        $display("FAIL rnd_idle[%0d] got=%b want=0", it,
                 {busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err});
      end
    end
  endtask

  task automatic test_reset_abort;
    logic win;
    drive(1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 3'b010);
    model_pick(1'b0, 1'b1, win);
    @(negedge clk);
    drop_reqs();
    tests_run++;
    if ({m1_gnt, mem_write} !== 2'b11) begin
      tests_failed++;
      $display("FAIL abort_access got gnt=%b wr=%b want 1/1", m1_gnt, mem_write);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write, busy,
         m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_funct3} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs got flags=%b addr=%h wdata=%h rdata=%h/%h want all 0",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write, busy},
               mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (m1_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_rvalid got=%b want=0", m1_rvalid);
    end
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 8'h20, 32'h0, 3'b010);
    model_pick(1'b1, 1'b0, win);
    @(negedge clk);
    drop_reqs();
    tests_run++;
    if ({m0_gnt, m1_gnt, mem_read} !== 3'b101) begin
      tests_failed++;
      $display("FAIL abort_regrant got gnt=%b rd=%b want 10/1", {m0_gnt, m1_gnt}, mem_read);
    end
    @(negedge clk);
    model_complete(win, 1'b0, 8'h20, 32'h0, 3'b010);
    tests_run++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, exp_rdata[0]}) begin
      tests_failed++;
      $display("FAIL abort_reload got rv=%b rdata=%h want 10/%h", {m0_rvalid, m1_rvalid}, m0_rdata, exp_rdata[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_funct3 = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_funct3 = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_reset();
    test_reset();
    test_load_store();
    test_misaligned();
    test_tie();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
